remote_comm: RTL



---
 rtl/remote_comm_pkg.sv | 25 ++
 rtl/uart_byte_tx.sv | 85 ++++++++
 rtl/remote_comm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/remote_comm_pkg.sv
// remote_comm_pkg
//   Shared types and constants for the host-side command initiator:
//   TX/RX state encodings, 8N1 line levels and frame geometry.
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPPER = 2'd1,
    LOWER = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;   // start + 8 data + stop
  localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx
//   Serializes one byte as an 8N1 frame (start, 8 data LSB first, stop),
//   each bit held BAUD_DIV clocks. A load on the cycle that done is high
//   starts the next frame with no idle gap. BAUD_DIV must be >= 4.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      start a frame with data (has priority over an active frame)
//   data      byte to send, captured on load
//   tx        serial line, registered, idle high
//   done      high in the last clock of the stop bit
module uart_byte_tx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic             tx_q, tx_d;
  logic [7:0]       data_q, data_d;

  // done depends only on state so the parent may use it to drive load.
  assign done = active_q && (cnt_q == CNT_MAX) && (bit_q == 4'(FRAME_BITS - 1));
  assign tx   = tx_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    data_d   = data_q;
    if (load) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
      tx_d     = START_BIT;
      data_d   = data;
    end else if (active_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          active_d = 1'b0;
          tx_d     = STOP_BIT;
        end else begin
          bit_d = bit_q + 4'd1;
          // Moving into bit position bit_q+1, which carries data[bit_q].
          if (bit_q < 4'(DATA_BITS)) tx_d = data_q[bit_q[2:0]];
          else                       tx_d = STOP_BIT;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= STOP_BIT;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/remote_comm.sv
// remote_comm
//   Host-side command initiator. Sends a 16-bit command as two back-to-back
//   8N1 bytes (upper first) on TX and independently receives 8-bit response
//   bytes on RX.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   snd_cmd       pulse: launch transmission of cmd (ignored unless idle)
//   cmd           command word, captured on an accepted snd_cmd
//   clr_resp_rdy  clears resp_rdy
//   RX            serial in from device (asynchronous)
//   TX            serial out to device, idle high
//   busy          high while a command is being transmitted
//   cmd_snt       one-cycle pulse after both bytes have been sent
//   resp          last good response byte
//   resp_rdy      resp holds a byte not yet acknowledged
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- TX side
  tx_state_t   state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic        load_first_q, load_first_d;
  logic        busy_q, busy_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        accept;
  logic        byte_load;
  logic [7:0]  byte_data;
  logic        byte_done;
  logic        tx_line;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    load_first_d = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          accept       = 1'b1;
          shadow_d     = cmd;
          load_first_d = 1'b1;
          state_d      = UPPER;
        end
      end
      UPPER:   if (byte_done) state_d = LOWER;
      LOWER:   if (byte_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The low byte is loaded on the upper byte's final clock so its start
    // bit follows the upper stop bit directly.
    byte_load = load_first_q || ((state_q == UPPER) && byte_done);
    byte_data = ((state_q == UPPER) && byte_done) ? shadow_q[7:0] : shadow_q[15:8];

    // busy rises with the first start bit and drops as DONE is entered.
    busy_d    = ((state_q == UPPER) || (state_q == LOWER)) && (state_d != DONE);
    cmd_snt_d = (state_d == DONE);
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .load (byte_load),
    .data (byte_data),
    .tx   (tx_line),
    .done (byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_first_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_snt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_first_q <= load_first_d;
      busy_q       <= busy_d;
      cmd_snt_q    <= cmd_snt_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign TX      = tx_line;
  assign busy    = busy_q;
  assign cmd_snt = cmd_snt_q;

  // ---------------------------------------------------------------- RX side
  rx_state_t        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_good;
  logic [7:0]       resp_q, resp_d;
  logic             resp_rdy_q, resp_rdy_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Arms only on a falling edge, so after a bad stop bit the line
        // must return high before another frame is recognised.
        if ((rx_prev_q == STOP_BIT) && (rx_sync_q == START_BIT)) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_MAX) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          if (rx_sync_q == START_BIT) rx_state_d = RX_DATA;
          else                        rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_MAX) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'(DATA_BITS - 1)) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_MAX) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_good    = (rx_sync_q == STOP_BIT);
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    resp_d = rx_good ? rx_shift_q : resp_q;
    // A new byte beats a simultaneous clear.
    if (rx_good)                      resp_rdy_d = 1'b1;
    else if (clr_resp_rdy || accept)  resp_rdy_d = 1'b0;
    else                              resp_rdy_d = resp_rdy_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule
